// File: rtl/cache_pkg.sv
// Shared types for the cache control path: CPU/memory opcodes and controller states.
package cache_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    STORE   = 2'd1,
    CLFLUSH = 2'd2
  } req_op_e;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    INSTALL   = 3'd4
  } cache_ctrl_state_e;

  // Index width for a line of `words` words; a one-word line still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bundle of CPU request, metadata/data array and memory request signals around the cache controller.
interface cache_controller_if #(
  parameter int unsigned WORD_IDX_W = 2
);

  logic                  req_valid;
  logic [1:0]            req_op;
  logic                  req_ready;
  logic                  req_fulfilled;

  logic                  valid_block_match;
  logic                  valid_dirty_bit;
  logic                  clear_selected_valid_bit;
  logic                  finish_new_line_install;
  logic                  clear_selected_dirty_bit;
  logic                  set_selected_dirty_bit;

  logic                  data_array_we;
  logic                  data_src_sel;
  logic [WORD_IDX_W-1:0] word_offset;

  logic                  mem_req_valid;
  logic                  mem_req_op;
  logic                  mem_addr_sel_tag;
  logic                  mem_req_fulfilled;

  // Controller side.
  modport master (
    input  req_valid, req_op, valid_block_match, valid_dirty_bit, mem_req_fulfilled,
    output req_ready, req_fulfilled,
           clear_selected_valid_bit, finish_new_line_install,
           clear_selected_dirty_bit, set_selected_dirty_bit,
           data_array_we, data_src_sel, word_offset,
           mem_req_valid, mem_req_op, mem_addr_sel_tag
  );

  // CPU, arrays and memory side.
  modport slave (
    output req_valid, req_op, valid_block_match, valid_dirty_bit, mem_req_fulfilled,
    input  req_ready, req_fulfilled,
           clear_selected_valid_bit, finish_new_line_install,
           clear_selected_dirty_bit, set_selected_dirty_bit,
           data_array_we, data_src_sel, word_offset,
           mem_req_valid, mem_req_op, mem_addr_sel_tag
  );

endinterface

// File: rtl/line_word_counter.sv
// Word index within a cache line during writeback/refill; wraps to 0 after the last word.
module line_word_counter
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned CNT_W          = idx_width(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_LINE - 1);

  assign last = (count == LAST_IDX);

  // Clear wins over increment so a state entry always starts at word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped cache control FSM: hit/miss handling, word-by-word writeback and refill, line flush.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned READ_ONLY      = 0,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned WORD_IDX_W     = idx_width(WORDS_PER_LINE)
) (
  input  logic               clk,
  input  logic               reset,
  cache_controller_if.master bus
);

  localparam bit RO = (READ_ONLY != 0);

  cache_ctrl_state_e       state_q, state_d;
  req_op_e                 op_q, op_d;
  logic                    flush_q, flush_set, flush_clr;
  logic                    cnt_clear, cnt_incr, cnt_last;
  logic [WORD_IDX_W-1:0]   cnt;
  logic                    dirty;

  // An I-cache never holds modified data, so the dirty status is meaningless there.
  assign dirty = RO ? 1'b0 : bus.valid_dirty_bit;

  // Request opcode as seen by the FSM; stores collapse to loads on a read-only cache.
  always_comb begin
    op_d = LOAD;
    case (bus.req_op)
      2'd1:    op_d = RO ? LOAD : STORE;
      2'd2:    op_d = CLFLUSH;
      default: op_d = LOAD;
    endcase
  end

  line_word_counter #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .CNT_W          (WORD_IDX_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .incr  (cnt_incr),
    .count (cnt),
    .last  (cnt_last)
  );

  assign bus.word_offset = cnt;

  // State, latched opcode and flush flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= LOAD;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        op_q <= op_d;
      end
      if (flush_set) begin
        flush_q <= 1'b1;
      end else if (flush_clr) begin
        flush_q <= 1'b0;
      end
    end
  end

  // Next state and strobes decoded straight from state, counter and incoming status.
  always_comb begin
    state_d                      = state_q;
    flush_set                    = 1'b0;
    flush_clr                    = 1'b0;
    cnt_clear                    = 1'b0;
    cnt_incr                     = 1'b0;
    bus.req_ready                = 1'b0;
    bus.req_fulfilled            = 1'b0;
    bus.clear_selected_valid_bit = 1'b0;
    bus.finish_new_line_install  = 1'b0;
    bus.clear_selected_dirty_bit = 1'b0;
    bus.set_selected_dirty_bit   = 1'b0;
    bus.data_array_we            = 1'b0;
    bus.data_src_sel             = 1'b0;
    bus.mem_req_valid            = 1'b0;
    bus.mem_req_op               = MEM_READ;
    bus.mem_addr_sel_tag         = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (op_q == CLFLUSH) begin
          if (dirty) begin
            flush_set = 1'b1;
            cnt_clear = 1'b1;
            state_d   = WRITEBACK;
          end else begin
            bus.clear_selected_valid_bit = 1'b1;
            bus.req_fulfilled            = 1'b1;
            state_d                      = IDLE;
          end
        end else if (bus.valid_block_match) begin
          bus.req_fulfilled = 1'b1;
          state_d           = IDLE;
          if (op_q == STORE) begin
            bus.data_array_we          = 1'b1;
            bus.data_src_sel           = 1'b0;
            bus.set_selected_dirty_bit = !RO;
          end
        end else begin
          cnt_clear = 1'b1;
          state_d   = dirty ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        bus.mem_req_valid    = 1'b1;
        bus.mem_req_op       = MEM_WRITE;
        bus.mem_addr_sel_tag = 1'b1;
        if (bus.mem_req_fulfilled) begin
          cnt_incr = 1'b1;
          if (cnt_last) begin
            cnt_clear = 1'b1;
            if (flush_q) begin
              flush_clr                    = 1'b1;
              bus.clear_selected_dirty_bit = !RO;
              bus.clear_selected_valid_bit = 1'b1;
              bus.req_fulfilled            = 1'b1;
              state_d                      = IDLE;
            end else begin
              state_d = ALLOCATE;
            end
          end
        end
      end

      ALLOCATE: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_op    = MEM_READ;
        if (bus.mem_req_fulfilled) begin
          bus.data_array_we = 1'b1;
          bus.data_src_sel  = 1'b1;
          cnt_incr          = 1'b1;
          if (cnt_last) begin
            state_d = INSTALL;
          end
        end
      end

      INSTALL: begin
        bus.finish_new_line_install  = 1'b1;
        bus.clear_selected_dirty_bit = !RO;
        state_d                      = COMPARE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: D-cache and I-cache instances against a set-level cache model.
module tb_cache_controller;
  import cache_pkg::*;

  localparam int unsigned W    = 4;
  localparam int unsigned SETS = 4;

  typedef struct packed {
    logic       ful;
    logic       we;
    logic       src;
    logic       clr_v;
    logic       fin;
    logic       clr_d;
    logic       set_d;
    logic       mdone;
    logic       mop;
    logic       msel;
    logic [1:0] off;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_op;
  logic       mem_ful;
  logic       sel_ro;
  logic       force_dirty;
  logic [1:0] cur_set;
  logic [3:0] cur_tag;

  logic       env_v [SETS];
  logic       env_d [SETS];
  logic [3:0] env_t [SETS];
  logic       ref_v [SETS];
  logic       ref_d [SETS];
  logic [3:0] ref_t [SETS];

  ev_t exp_q[$];
  int  exp_min;
  bit  exp_exact;
  int  n_total = 0;
  int  n_pass  = 0;
  ev_t pend;

  cache_controller_if #(.WORD_IDX_W(2)) bus    ();
  cache_controller_if #(.WORD_IDX_W(2)) bus_ro ();

  cache_controller #(.READ_ONLY(0), .WORDS_PER_LINE(W), .WORD_IDX_W(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cache_controller #(.READ_ONLY(1), .WORDS_PER_LINE(W), .WORD_IDX_W(2)) u_dut_ro (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_ro)
  );

  initial forever #5 clk = ~clk;

  logic vbm, vdb;
  assign vbm = env_v[cur_set] && (env_t[cur_set] == cur_tag);
  assign vdb = force_dirty | (env_v[cur_set] & env_d[cur_set]);

  assign bus.req_valid            = req_valid & ~sel_ro;
  assign bus.req_op               = req_op;
  assign bus.valid_block_match    = vbm;
  assign bus.valid_dirty_bit      = vdb;
  assign bus.mem_req_fulfilled    = mem_ful & ~sel_ro;
  assign bus_ro.req_valid         = req_valid & sel_ro;
  assign bus_ro.req_op            = req_op;
  assign bus_ro.valid_block_match = vbm;
  assign bus_ro.valid_dirty_bit   = vdb;
  assign bus_ro.mem_req_fulfilled = mem_ful & sel_ro;

  wire       m_ready = sel_ro ? bus_ro.req_ready                : bus.req_ready;
  wire       m_ful   = sel_ro ? bus_ro.req_fulfilled            : bus.req_fulfilled;
  wire       m_clr_v = sel_ro ? bus_ro.clear_selected_valid_bit : bus.clear_selected_valid_bit;
  wire       m_fin   = sel_ro ? bus_ro.finish_new_line_install  : bus.finish_new_line_install;
  wire       m_clr_d = sel_ro ? bus_ro.clear_selected_dirty_bit : bus.clear_selected_dirty_bit;
  wire       m_set_d = sel_ro ? bus_ro.set_selected_dirty_bit   : bus.set_selected_dirty_bit;
  wire       m_we    = sel_ro ? bus_ro.data_array_we            : bus.data_array_we;
  wire       m_src   = sel_ro ? bus_ro.data_src_sel             : bus.data_src_sel;
  wire [1:0] m_off   = sel_ro ? bus_ro.word_offset              : bus.word_offset;
  wire       m_mv    = sel_ro ? bus_ro.mem_req_valid            : bus.mem_req_valid;
  wire       m_mop   = sel_ro ? bus_ro.mem_req_op               : bus.mem_req_op;
  wire       m_msel  = sel_ro ? bus_ro.mem_addr_sel_tag         : bus.mem_addr_sel_tag;

  wire [12:0] outs0 = {bus.req_ready, bus.req_fulfilled, bus.clear_selected_valid_bit,
                       bus.finish_new_line_install, bus.clear_selected_dirty_bit,
                       bus.set_selected_dirty_bit, bus.data_array_we, bus.data_src_sel,
                       bus.word_offset, bus.mem_req_valid, bus.mem_req_op, bus.mem_addr_sel_tag};
  wire [12:0] outs1 = {bus_ro.req_ready, bus_ro.req_fulfilled, bus_ro.clear_selected_valid_bit,
                       bus_ro.finish_new_line_install, bus_ro.clear_selected_dirty_bit,
                       bus_ro.set_selected_dirty_bit, bus_ro.data_array_we, bus_ro.data_src_sel,
                       bus_ro.word_offset, bus_ro.mem_req_valid, bus_ro.mem_req_op,
                       bus_ro.mem_addr_sel_tag};
  localparam logic [12:0] RESET_OUTS = 13'h1000;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic ev_t mem_ev(input bit wr, input int i);
    ev_t e = '0;
    e.mdone = 1'b1;
    e.mop   = wr;
    e.msel  = wr;
    e.off   = 2'(i);
    e.we    = !wr;
    e.src   = !wr;
    return e;
  endfunction

  // Expected strobe cycles for one request, derived from set contents and the cache policy.
  function automatic void model(input logic [1:0] op, input int s, input logic [3:0] t, input bit ro);
    ev_t e;
    int  eff;
    bit  hit, dirty;
    eff   = (ro && op == 2'd1) ? 0 : int'(op);
    hit   = ref_v[s] && (ref_t[s] == t);
    dirty = !ro && ref_v[s] && ref_d[s];
    if (eff == 2) begin
      if (dirty) begin
        for (int i = 0; i < W; i++) begin
          e = mem_ev(1'b1, i);
          if (i == W - 1) begin e.ful = 1'b1; e.clr_v = 1'b1; e.clr_d = 1'b1; end
          exp_q.push_back(e);
        end
        exp_min = 1 + W; exp_exact = 1'b0;
        ref_d[s] = 1'b0;
      end else begin
        e = '0; e.clr_v = 1'b1; e.ful = 1'b1;
        exp_q.push_back(e);
        exp_min = 1; exp_exact = 1'b1;
      end
      ref_v[s] = 1'b0;
      return;
    end
    exp_min = 1; exp_exact = hit;
    if (!hit) begin
      if (dirty) begin
        for (int i = 0; i < W; i++) exp_q.push_back(mem_ev(1'b1, i));
        exp_min += W;
      end
      for (int i = 0; i < W; i++) exp_q.push_back(mem_ev(1'b0, i));
      e = '0; e.fin = 1'b1; e.clr_d = !ro;
      exp_q.push_back(e);
      exp_min += W + 2;
      ref_v[s] = 1'b1; ref_t[s] = t; ref_d[s] = 1'b0;
    end
    e = '0; e.ful = 1'b1;
    if (eff == 1) begin e.we = 1'b1; e.set_d = 1'b1; ref_d[s] = 1'b1; end
    exp_q.push_back(e);
  endfunction

  // Monitor: every cycle with a visible strobe or completed memory word is one scoreboard entry.
  initial forever begin
    ev_t got, want;
    @(negedge clk);
    got = '0;
    if (!reset) begin
      got.ful   = m_ful;
      got.we    = m_we;
      got.src   = m_we & m_src;
      got.clr_v = m_clr_v;
      got.fin   = m_fin;
      got.clr_d = m_clr_d;
      got.set_d = m_set_d;
      got.mdone = m_mv & mem_ful;
      got.mop   = got.mdone & m_mop;
      got.msel  = got.mdone & m_msel;
      got.off   = got.mdone ? m_off : 2'd0;
      if (got != '0) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_event", longint'(got), 0);
        end else begin
          want = exp_q.pop_front();
          check(got == want, "event", longint'(got), longint'(want));
        end
      end
    end
    pend = got;
  end

  // Environment: metadata arrays follow the controller's strobes; memory completes words at random.
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset) begin
      if (pend.clr_v) env_v[cur_set] = 1'b0;
      if (pend.fin) begin env_v[cur_set] = 1'b1; env_t[cur_set] = cur_tag; end
      if (pend.set_d) env_d[cur_set] = 1'b1;
      if (pend.clr_d) env_d[cur_set] = 1'b0;
    end
    mem_ful = m_mv && ($urandom_range(0, 1) == 1);
  end

  task automatic issue(input logic [1:0] op, input int s, input logic [3:0] t);
    int lat;
    @(negedge clk);
    lat = 0;
    while (!m_ready && lat < 50) begin @(negedge clk); lat++; end
    check(m_ready, "req_ready_idle", longint'(m_ready), 1);
    cur_set = 2'(s);
    cur_tag = t;
    req_op  = op;
    model(op, s, t, sel_ro);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check(!m_ready, "req_ready_busy", longint'(m_ready), 0);
    end while (!m_ful && lat < 400);
    if (exp_exact) check(m_ful && lat == exp_min, "latency", lat, exp_min);
    else           check(m_ful && lat >= exp_min, "latency_min", lat, exp_min);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    ev_t e;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; mem_ful = 1'b0;
    sel_ro = 1'b0; force_dirty = 1'b0; cur_set = 2'd0; cur_tag = 4'd0;
    for (int i = 0; i < SETS; i++) begin
      env_v[i] = 1'b0; env_d[i] = 1'b0; env_t[i] = 4'd0;
      ref_v[i] = 1'b0; ref_d[i] = 1'b0; ref_t[i] = 4'd0;
    end
    #23;
    check(outs0 == RESET_OUTS, "reset_outs_dcache", longint'(outs0), longint'(RESET_OUTS));
    check(outs1 == RESET_OUTS, "reset_outs_icache", longint'(outs1), longint'(RESET_OUTS));
    @(negedge clk);
    reset = 1'b0;

    issue(2'd0, 2, 4'd5);
    issue(2'd0, 2, 4'd5);
    issue(2'd0, 1, 4'd3);
    issue(2'd1, 2, 4'd5);
    issue(2'd0, 2, 4'd9);
    issue(2'd1, 1, 4'd3);
    issue(2'd2, 1, 4'd3);
    issue(2'd2, 2, 4'd9);

    // Reset while the third refill word is outstanding; set 3 is still empty so the model is unchanged.
    @(negedge clk);
    cur_set = 2'd3; cur_tag = 4'd7; req_op = 2'd0;
    exp_q.push_back(mem_ev(1'b0, 0));
    exp_q.push_back(mem_ev(1'b0, 1));
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #2; lat++; end while (!(m_mv && m_off == 2'd2) && lat < 200);
    check(m_mv && m_off == 2'd2, "reach_word2", longint'(m_off), 2);
    reset = 1'b1;
    #1;
    check(outs0 == RESET_OUTS, "midalloc_reset_outs", longint'(outs0), longint'(RESET_OUTS));
    check(exp_q.size() == 0, "midalloc_words_done", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end

    @(negedge clk);
    sel_ro = 1'b1;
    force_dirty = 1'b1;
    issue(2'd0, 0, 4'd1);
    issue(2'd1, 0, 4'd1);
    issue(2'd1, 0, 4'd2);
    for (int n = 0; n < 15; n++) begin
      issue(2'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
